// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding and default geometry.
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } loader_state_e;

  localparam int ROM_SIZE_DEF    = 512;
  localparam int INSTR_WIDTH_DEF = 9;

endpackage

// File: rtl/instr_loader_if.sv
// Producer word stream into the loader plus the loader's write port toward instruction memory.
interface instr_loader_if #(
  parameter int rom_size    = loader_pkg::ROM_SIZE_DEF,
  parameter int instr_width = loader_pkg::INSTR_WIDTH_DEF
);
  localparam int AW = $clog2(rom_size) + 1;

  logic                   in_valid;
  logic [instr_width-1:0] in_data;
  logic                   in_last;
  logic                   in_ready;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [instr_width-1:0] wr_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/instr_loader.sv
// Streams a program image into instruction memory; writes land 1 cycle after acceptance.
// Backpressure: in_ready is high only while loading; start is ignored mid-load.
module instr_loader
  import loader_pkg::*;
#(
  parameter int rom_size    = ROM_SIZE_DEF,
  parameter int instr_width = INSTR_WIDTH_DEF,
  localparam int AW         = $clog2(rom_size) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  instr_loader_if.slave          bus,
  output logic [AW-1:0]          count,
  output logic [instr_width-1:0] checksum,
  output logic                   done,
  output logic                   overflow,
  output logic                   cpu_hold
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] LOAD = ST_LOAD;
  localparam logic [1:0] DONE = ST_DONE;
  localparam logic [1:0] ERR  = ST_ERR;

  localparam logic [AW-1:0] LAST_ADDR = AW'(rom_size - 1);

  logic [1:0]             state;
  logic [AW-1:0]          ptr;
  logic                   accept;
  logic                   wr_en_q;
  logic [AW-1:0]          wr_addr_q;
  logic [instr_width-1:0] wr_data_q;

  assign bus.in_ready = (state == LOAD);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      count     <= '0;
      checksum  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= ptr;
        wr_data_q <= bus.in_data;
      end

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LOAD;
            ptr      <= '0;
            count    <= '0;
            checksum <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            ptr      <= ptr + AW'(1);
            count    <= count + AW'(1);
            checksum <= checksum ^ bus.in_data;
            // in_last wins over a full memory so an exact fit still counts as success
            if (bus.in_last) begin
              state <= DONE;
            end else if (ptr == LAST_ADDR) begin
              state <= ERR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  assign done     = (state == DONE);
  assign overflow = (state == ERR);
  // hold the core until the last accepted word has actually been written
  assign cpu_hold = (state == LOAD) || wr_en_q;

  wr_in_range: assert property (@(posedge clk) disable iff (reset)
    wr_en_q |-> (wr_addr_q <= LAST_ADDR));

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a 512-word instance and an 8-word instance share clk/reset.
module tb_instr_loader;
  import loader_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start_a, start_b;

  int checks = 0;
  int errors = 0;

  instr_loader_if #(.rom_size(512), .instr_width(9)) bus_a ();
  instr_loader_if #(.rom_size(8),   .instr_width(9)) bus_b ();

  logic [9:0] count_a;
  logic [8:0] checksum_a;
  logic       done_a, overflow_a, cpu_hold_a;
  logic [3:0] count_b;
  logic [8:0] checksum_b;
  logic       done_b, overflow_b, cpu_hold_b;

  instr_loader #(.rom_size(512), .instr_width(9)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a),
    .count(count_a), .checksum(checksum_a), .done(done_a),
    .overflow(overflow_a), .cpu_hold(cpu_hold_a)
  );

  instr_loader #(.rom_size(8), .instr_width(9)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b),
    .count(count_b), .checksum(checksum_b), .done(done_b),
    .overflow(overflow_b), .cpu_hold(cpu_hold_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input logic [8:0] d, input logic last);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.in_last  = last;
  endtask

  task automatic beat_b(input logic [8:0] d, input logic last);
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = d;
    bus_b.in_last  = last;
  endtask

  task automatic idle_inputs;
    bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0; bus_a.in_data = '0;
    bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0; bus_b.in_data = '0;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  initial begin
    // reset held 2 cycles while start and in_valid are asserted
    reset = 1'b1; start_a = 1'b1; start_b = 1'b1;
    beat_a(9'h1AB, 1'b0);
    beat_b(9'h0CD, 1'b0);
    tick; tick;
    check("rst_state_a",    32'(dut_a.state), 32'(ST_IDLE));
    check("rst_wr_en_a",    32'(bus_a.wr_en), 0);
    check("rst_wr_addr_a",  32'(bus_a.wr_addr), 0);
    check("rst_wr_data_a",  32'(bus_a.wr_data), 0);
    check("rst_in_ready_a", 32'(bus_a.in_ready), 0);
    check("rst_count_a",    32'(count_a), 0);
    check("rst_checksum_a", 32'(checksum_a), 0);
    check("rst_done_a",     32'(done_a), 0);
    check("rst_overflow_a", 32'(overflow_a), 0);
    check("rst_cpu_hold_a", 32'(cpu_hold_a), 0);
    check("rst_state_b",    32'(dut_b.state), 32'(ST_IDLE));
    check("rst_cpu_hold_b", 32'(cpu_hold_b), 0);
    reset = 1'b0;
    idle_inputs;
    tick;

    // full 33-word program, back to back
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    check("full_in_ready", 32'(bus_a.in_ready), 1);
    check("full_hold_load", 32'(cpu_hold_a), 1);
    for (int i = 0; i < 33; i++) begin
      beat_a(9'(i + 1), (i == 32));
      tick;
      check($sformatf("full_wr_en_%0d", i),   32'(bus_a.wr_en), 1);
      check($sformatf("full_wr_addr_%0d", i), 32'(bus_a.wr_addr), 32'(i));
      check($sformatf("full_wr_data_%0d", i), 32'(bus_a.wr_data), 32'(i + 1));
    end
    idle_inputs;
    check("full_done",     32'(done_a), 1);
    check("full_count",    32'(count_a), 33);
    check("full_checksum", 32'(checksum_a), 32'h001);
    check("full_hold_last_write", 32'(cpu_hold_a), 1);
    check("full_in_ready_done", 32'(bus_a.in_ready), 0);
    tick;
    check("full_wr_en_after", 32'(bus_a.wr_en), 0);
    check("full_hold_fall",   32'(cpu_hold_a), 0);
    check("full_count_hold",  32'(count_a), 33);
    check("full_done_hold",   32'(done_a), 1);

    // gaps in in_valid: A, gap, gap, B(last)
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    check("gap_done_drop",  32'(done_a), 0);
    check("gap_count_clr",  32'(count_a), 0);
    check("gap_cksum_clr",  32'(checksum_a), 0);
    beat_a(9'h0AA, 1'b0);
    tick;
    idle_inputs;
    check("gap_wr_en_a",   32'(bus_a.wr_en), 1);
    check("gap_wr_addr_a", 32'(bus_a.wr_addr), 0);
    check("gap_wr_data_a", 32'(bus_a.wr_data), 32'h0AA);
    tick;
    check("gap_wr_en_gap1", 32'(bus_a.wr_en), 0);
    tick;
    check("gap_wr_en_gap2", 32'(bus_a.wr_en), 0);
    beat_a(9'h155, 1'b1);
    tick;
    idle_inputs;
    check("gap_wr_en_b",   32'(bus_a.wr_en), 1);
    check("gap_wr_addr_b", 32'(bus_a.wr_addr), 1);
    check("gap_wr_data_b", 32'(bus_a.wr_data), 32'h155);
    check("gap_count",     32'(count_a), 2);
    check("gap_checksum",  32'(checksum_a), 32'h1FF);
    check("gap_done",      32'(done_a), 1);
    tick;
    check("gap_wr_en_end", 32'(bus_a.wr_en), 0);

    // overflow on the 8-word instance: 9 words, no in_last
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_in_ready_%0d", i), 32'(bus_b.in_ready), 1);
      beat_b(9'(1 << i), 1'b0);
      tick;
      check($sformatf("ovf_wr_en_%0d", i),   32'(bus_b.wr_en), 1);
      check($sformatf("ovf_wr_addr_%0d", i), 32'(bus_b.wr_addr), 32'(i));
    end
    check("ovf_flag",      32'(overflow_b), 1);
    check("ovf_done",      32'(done_b), 0);
    check("ovf_in_ready",  32'(bus_b.in_ready), 0);
    beat_b(9'h100, 1'b0);
    tick;
    idle_inputs;
    check("ovf_ninth_wr_en", 32'(bus_b.wr_en), 0);
    check("ovf_count",       32'(count_b), 8);
    check("ovf_checksum",    32'(checksum_b), 32'h0FF);
    check("ovf_flag_hold",   32'(overflow_b), 1);
    check("ovf_hold_off",    32'(cpu_hold_b), 0);

    // exact fill: 8 words, in_last on the 8th
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    check("fill_ovf_drop", 32'(overflow_b), 0);
    for (int i = 0; i < 8; i++) begin
      beat_b(9'(1 << i), (i == 7));
      tick;
      check($sformatf("fill_wr_addr_%0d", i), 32'(bus_b.wr_addr), 32'(i));
    end
    idle_inputs;
    check("fill_done",     32'(done_b), 1);
    check("fill_overflow", 32'(overflow_b), 0);
    check("fill_count",    32'(count_b), 8);
    check("fill_checksum", 32'(checksum_b), 32'h0FF);

    // reset after 5 accepted words, with a 6th word on the bus at the reset edge
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat_a(9'(9'h050 + i), 1'b0);
      tick;
    end
    check("mid_count_5", 32'(count_a), 5);
    beat_a(9'h055, 1'b0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    idle_inputs;
    check("mid_state",    32'(dut_a.state), 32'(ST_IDLE));
    check("mid_count",    32'(count_a), 0);
    check("mid_wr_en",    32'(bus_a.wr_en), 0);
    check("mid_cpu_hold", 32'(cpu_hold_a), 0);

    // start with in_valid in IDLE accepts nothing
    start_a = 1'b1;
    beat_a(9'h0C0, 1'b0);
    tick;
    check("idle_start_no_wr", 32'(bus_a.wr_en), 0);
    check("idle_start_count", 32'(count_a), 0);
    // start stays high during LOAD and must be ignored
    tick;
    check("re_wr_en_0",   32'(bus_a.wr_en), 1);
    check("re_wr_addr_0", 32'(bus_a.wr_addr), 0);
    check("re_wr_data_0", 32'(bus_a.wr_data), 32'h0C0);
    beat_a(9'h0C1, 1'b1);
    tick;
    idle_inputs;
    check("re_wr_addr_1", 32'(bus_a.wr_addr), 1);
    check("re_wr_data_1", 32'(bus_a.wr_data), 32'h0C1);
    check("re_count",     32'(count_a), 2);
    check("re_checksum",  32'(checksum_a), 32'h001);
    check("re_done",      32'(done_a), 1);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
